boo_function: RTL and testbench

- Clocked 3-input Boolean function evaluator.
- Each accepted sample {a,b,c} indexes an 8-entry truth table; the selected bit is registered onto y.
- The truth table resets to a fixed default function and can be reprogrammed at runtime.
- Used as a small configurable logic cell; it also keeps evaluation and ones-count statistics for debug.

---
 rtl/boo_function_if.sv | 38 +++
 rtl/boo_function.sv | 90 +++++++++
 tb/tb_boo_function.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/boo_function_if.sv
// Signal bundle for the boo_function logic cell.
//
// Handshake: a sample {a,b,c} is accepted on every rising clk edge where
// in_valid=1; there is no ready, the cell never stalls. The result appears on
// y/minterm one cycle later, qualified by a single-cycle out_valid pulse.
// cfg_we/cfg_tt and cnt_clr are plain edge-sampled strobes with no handshake.
interface boo_function_if #(
  parameter int CNT_W = 16
);
  // Sample and control inputs of the cell
  logic             a;
  logic             b;
  logic             c;
  logic             in_valid;
  logic             cfg_we;
  logic [7:0]       cfg_tt;
  logic             cnt_clr;

  // Registered results and debug state of the cell
  logic             y;
  logic             out_valid;
  logic [2:0]       minterm;
  logic [7:0]       tt;
  logic [CNT_W-1:0] eval_cnt;
  logic [CNT_W-1:0] ones_cnt;

  // Driver side: whoever feeds samples and configuration
  modport master (
    output a, b, c, in_valid, cfg_we, cfg_tt, cnt_clr,
    input  y, out_valid, minterm, tt, eval_cnt, ones_cnt
  );

  // Cell side
  modport slave (
    input  a, b, c, in_valid, cfg_we, cfg_tt, cnt_clr,
    output y, out_valid, minterm, tt, eval_cnt, ones_cnt
  );
endinterface

// File: rtl/boo_function.sv
// Clocked 3-input Boolean function evaluator.
// Each accepted sample {a,b,c} selects one bit of an 8-entry truth table and
// registers it onto y. The table is runtime-programmable and resets to
// DEFAULT_TT. Two saturating counters track evaluations and ones produced.
// There is no state machine: the only state is the table, the result
// registers and the two counters.
module boo_function #(
  parameter logic [7:0] DEFAULT_TT = 8'hE2,
  parameter int         CNT_W      = 16
) (
  input logic          clk,
  input logic          rst_n,
  boo_function_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [7:0]       tt_q;
  logic             y_q;
  logic             out_valid_q;
  logic [2:0]       minterm_q;
  logic [CNT_W-1:0] eval_cnt_q;
  logic [CNT_W-1:0] ones_cnt_q;

  logic [2:0]       idx;
  logic             new_bit;

  // Table lookup from the current (old) table; a same-cycle cfg_we only takes
  // effect for samples on later edges.
  always_comb begin
    idx     = {bus.a, bus.b, bus.c};
    new_bit = tt_q[idx];
  end

  // Truth table storage; reset always restores the default function.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q <= DEFAULT_TT;
    end else if (bus.cfg_we) begin
      tt_q <= bus.cfg_tt;
    end
  end

  // Result registers: update on accepted samples, hold otherwise so idle
  // (possibly X) inputs never reach y or minterm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= 1'b0;
      minterm_q   <= 3'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        y_q       <= new_bit;
        minterm_q <= idx;
      end
    end
  end

  // Evaluation counter: saturating, clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      eval_cnt_q <= '0;
    end else if (bus.in_valid && (eval_cnt_q != CNT_MAX)) begin
      eval_cnt_q <= eval_cnt_q + CNT_ONE;
    end
  end

  // Ones counter: counts evaluations whose freshly computed result is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      ones_cnt_q <= '0;
    end else if (bus.in_valid && new_bit && (ones_cnt_q != CNT_MAX)) begin
      ones_cnt_q <= ones_cnt_q + CNT_ONE;
    end
  end

  assign bus.y         = y_q;
  assign bus.out_valid = out_valid_q;
  assign bus.minterm   = minterm_q;
  assign bus.tt        = tt_q;
  assign bus.eval_cnt  = eval_cnt_q;
  assign bus.ones_cnt  = ones_cnt_q;

endmodule

// File: tb/tb_boo_function.sv
// Directed bench for boo_function with a small counter width so saturation
// is reachable. Expected {y,minterm} pairs are queued when a sample is driven
// and popped when the cell reports out_valid.
module tb_boo_function;

  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;

  boo_function_if #(.CNT_W(CNT_W)) bus ();

  boo_function #(
    .DEFAULT_TT(8'hE2),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Clock: period 10, inputs change on negedge, outputs checked on negedge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];      // {y, minterm}
  logic [7:0] model_tt;
  logic       last_y;
  logic [2:0] last_m;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, wait for the sampling edge, then check the result
  task automatic step(input logic iv, input logic [2:0] abc,
                      input logic we, input logic [7:0] new_tt, input logic clr);
    logic [3:0] e;
    bus.in_valid = iv;
    {bus.a, bus.b, bus.c} = abc;
    bus.cfg_we  = we;
    bus.cfg_tt  = new_tt;
    bus.cnt_clr = clr;
    if (iv) begin
      exp_q.push_back({model_tt[abc], abc});
      last_y = model_tt[abc];
      last_m = abc;
    end
    if (we) model_tt = new_tt;
    @(negedge clk);
    chk("out_valid", {7'd0, bus.out_valid}, {7'd0, iv});
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 8'd1, 8'd0);
      end else begin
        e = exp_q.pop_front();
        chk("y", {7'd0, bus.y}, {7'd0, e[3]});
        chk("minterm", {5'd0, bus.minterm}, {5'd0, e[2:0]});
      end
    end else begin
      chk("y_hold", {7'd0, bus.y}, {7'd0, last_y});
      chk("minterm_hold", {5'd0, bus.minterm}, {5'd0, last_m});
    end
    bus.cfg_we  = 1'b0;
    bus.cnt_clr = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    bus.a = 1'b0; bus.b = 1'b0; bus.c = 1'b0;
    bus.in_valid = 1'b0; bus.cfg_we = 1'b0; bus.cfg_tt = 8'h00; bus.cnt_clr = 1'b0;
    model_tt = 8'hE2;
    last_y = 1'b0;
    last_m = 3'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_y", {7'd0, bus.y}, 8'd0);
    chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("rst_minterm", {5'd0, bus.minterm}, 8'd0);
    chk("rst_tt", bus.tt, 8'hE2);
    chk("rst_eval_cnt", {4'd0, bus.eval_cnt}, 8'd0);
    chk("rst_ones_cnt", {4'd0, bus.ones_cnt}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default sweep: y = 0,1,0,0,0,1,1,1
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 1'b0, 8'h00, 1'b0);
    chk("sweep_eval_cnt", {4'd0, bus.eval_cnt}, 8'd8);
    chk("sweep_ones_cnt", {4'd0, bus.ones_cnt}, 8'd4);

    // Reprogram to 3-input parity
    step(1'b0, 3'd0, 1'b1, 8'h96, 1'b0);
    chk("parity_tt", bus.tt, 8'h96);
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 1'b0, 8'h00, 1'b0);

    // Same-cycle config and eval: old table applies to that sample
    step(1'b0, 3'd0, 1'b1, 8'hE2, 1'b0);
    step(1'b1, 3'd7, 1'b1, 8'h00, 1'b0);
    chk("same_cycle_y_old", {7'd0, bus.y}, 8'd1);
    step(1'b1, 3'd7, 1'b0, 8'h00, 1'b0);
    chk("same_cycle_y_new", {7'd0, bus.y}, 8'd0);

    // Hold and pulse: one evaluation, then idle with toggling inputs
    step(1'b0, 3'd0, 1'b1, 8'hE2, 1'b0);
    step(1'b1, 3'd5, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 3'($urandom_range(0, 7)), 1'b0, 8'h00, 1'b0);
    chk("hold_y", {7'd0, bus.y}, 8'd1);
    chk("hold_minterm", {5'd0, bus.minterm}, 8'd5);

    // Saturation: clear, then 20 evaluations of abc=111 (y=1)
    step(1'b0, 3'd0, 1'b0, 8'h00, 1'b1);
    chk("clr_eval_cnt", {4'd0, bus.eval_cnt}, 8'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 3'd7, 1'b0, 8'h00, 1'b0);
    chk("sat_eval_cnt", {4'd0, bus.eval_cnt}, 8'd15);
    chk("sat_ones_cnt", {4'd0, bus.ones_cnt}, 8'd15);
    // Clear together with an evaluation: clear wins, y still updates
    step(1'b1, 3'd0, 1'b0, 8'h00, 1'b1);
    chk("clr_eval_eval_cnt", {4'd0, bus.eval_cnt}, 8'd0);
    chk("clr_eval_ones_cnt", {4'd0, bus.ones_cnt}, 8'd0);
    step(1'b1, 3'd7, 1'b0, 8'h00, 1'b0);
    chk("post_clr_eval_cnt", {4'd0, bus.eval_cnt}, 8'd1);
    chk("post_clr_ones_cnt", {4'd0, bus.ones_cnt}, 8'd1);

    // Asynchronous reset mid-stream after loading parity
    step(1'b0, 3'd0, 1'b1, 8'h96, 1'b0);
    bus.in_valid = 1'b1;
    {bus.a, bus.b, bus.c} = 3'b001;
    @(posedge clk);
    #1;
    chk("pre_rst_y", {7'd0, bus.y}, 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_y", {7'd0, bus.y}, 8'd0);
    chk("async_rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("async_rst_tt", bus.tt, 8'hE2);
    chk("async_rst_eval_cnt", {4'd0, bus.eval_cnt}, 8'd0);
    exp_q.delete();
    model_tt = 8'hE2;
    last_y = 1'b0;
    last_m = 3'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 3'd1, 1'b0, 8'h00, 1'b0);
    chk("post_rst_y", {7'd0, bus.y}, 8'd1);
    chk("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
